// File: rtl/game_flow_controller.sv
// -----------------------------------------------------------------------------
// game_flow_controller
//
// Top-level sequencer for the symbol-counter game. Runs the round cycle
// IDLE -> PRELIM (countdown) -> PLAY -> next round, and owns the current
// level, remaining lives and the per-round play timer. Decides win/lose.
//
// Ports
//   Clk100M        in   system clock, all state on its rising edge
//   Rst_n          in   asynchronous active-low reset
//   Clk1Hz         in   1 Hz level, 2-flop synchronised then edge detected
//   startBtn       in   single-cycle start pulse (IDLE / WIN / LOSE only)
//   prelimDone     in   countdown-complete level, rising edge used in PRELIM
//   answerValid    in   single-cycle answer pulse (PLAY only)
//   answerCorrect  in   qualifies answerValid
//   prelimSig      out  high throughout PRELIM
//   playEn         out  high throughout PLAY
//   curLevel       out  current level 0..MAX_LEVEL
//   livesLeft      out  remaining lives
//   secondsLeft    out  play seconds remaining
//   state          out  FSM state: IDLE=0 PRELIM=1 PLAY=2 WIN=3 LOSE=4
//   gameWon        out  high in WIN
//   gameOver       out  high in LOSE
//
// Handshake: there is no ready/back-pressure. answerValid and startBtn are
// one-cycle pulses that are consumed in the cycle they are sampled if the
// FSM is in a state that accepts them, and silently dropped otherwise.
// -----------------------------------------------------------------------------
module game_flow_controller #(
   parameter int MAX_LEVEL    = 9,
   parameter int PLAY_SECONDS = 10,
   parameter int LIVES        = 3
) (
   input  logic       Clk100M,
   input  logic       Rst_n,
   input  logic       Clk1Hz,
   input  logic       startBtn,
   input  logic       prelimDone,
   input  logic       answerValid,
   input  logic       answerCorrect,
   output logic       prelimSig,
   output logic       playEn,
   output logic [3:0] curLevel,
   output logic [1:0] livesLeft,
   output logic [3:0] secondsLeft,
   output logic [2:0] state,
   output logic       gameWon,
   output logic       gameOver
);

   localparam logic [3:0] MAX_LEVEL_C = 4'(MAX_LEVEL);
   localparam logic [3:0] PLAY_SEC_C  = 4'(PLAY_SECONDS);
   localparam logic [1:0] LIVES_C     = 2'(LIVES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRELIM = 3'd1,
      S_PLAY   = 3'd2,
      S_WIN    = 3'd3,
      S_LOSE   = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] level_q, level_d;
   logic [1:0] lives_q, lives_d;
   logic [3:0] secs_q, secs_d;

   // 1 Hz synchroniser and edge detector
   logic       hz_s1_q, hz_s2_q, hz_prev_q;
   logic       hz_tick;

   // prelimDone edge detector; the rise pulse is registered and only
   // armed while in PRELIM, so a level that was already high on entry
   // (or an edge seen in another state) never starts PLAY.
   logic       pd_q;
   logic       pd_rise_q, pd_rise_d;

   logic       lose_life;

   assign hz_tick   = hz_s2_q & ~hz_prev_q;
   assign pd_rise_d = prelimDone & ~pd_q & (state_q == S_PRELIM);

   always_ff @(posedge Clk100M or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         level_q   <= 4'd0;
         lives_q   <= LIVES_C;
         secs_q    <= 4'd0;
         hz_s1_q   <= 1'b0;
         hz_s2_q   <= 1'b0;
         hz_prev_q <= 1'b0;
         pd_q      <= 1'b0;
         pd_rise_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         level_q   <= level_d;
         lives_q   <= lives_d;
         secs_q    <= secs_d;
         hz_s1_q   <= Clk1Hz;
         hz_s2_q   <= hz_s1_q;
         hz_prev_q <= hz_s2_q;
         pd_q      <= prelimDone;
         pd_rise_q <= pd_rise_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      level_d   = level_q;
      lives_d   = lives_q;
      secs_d    = secs_q;
      lose_life = 1'b0;

      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (startBtn) begin
               state_d = S_PRELIM;
               level_d = 4'd0;
               lives_d = LIVES_C;
            end
         end
         S_PRELIM: begin
            if (pd_rise_q) begin
               state_d = S_PLAY;
               secs_d  = PLAY_SEC_C;
            end
         end
         S_PLAY: begin
            // An answer outranks a same-cycle 1 Hz tick; the tick is dropped.
            if (answerValid && answerCorrect) begin
               if (level_q >= MAX_LEVEL_C) begin
                  state_d = S_WIN;
               end else begin
                  level_d = level_q + 4'd1;
                  state_d = S_PRELIM;
               end
            end else if (answerValid) begin
               lose_life = 1'b1;
            end else if (hz_tick) begin
               if (secs_q == 4'd1) begin
                  secs_d    = 4'd0;
                  lose_life = 1'b1;
               end else if (secs_q != 4'd0) begin
                  secs_d = secs_q - 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (lose_life) begin
         if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = S_LOSE;
         end else begin
            lives_d = lives_q - 2'd1;
            state_d = S_PRELIM;
         end
      end
   end

   assign state       = state_q;
   assign prelimSig   = (state_q == S_PRELIM);
   assign playEn      = (state_q == S_PLAY);
   assign gameWon     = (state_q == S_WIN);
   assign gameOver    = (state_q == S_LOSE);
   assign curLevel    = level_q;
   assign livesLeft   = lives_q;
   assign secondsLeft = secs_q;

endmodule

// File: tb/tb_game_flow_controller.sv
module tb_game_flow_controller;

   logic       clk;
   logic       rst_n;
   logic       clk_1hz;
   logic       start_btn;
   logic       prelim_done;
   logic       answer_valid;
   logic       answer_correct;
   logic       prelim_sig;
   logic       play_en;
   logic [3:0] cur_level;
   logic [1:0] lives_left;
   logic [3:0] seconds_left;
   logic [2:0] state;
   logic       game_won;
   logic       game_over;

   int n_vec;
   int n_err;

   game_flow_controller #(
      .MAX_LEVEL(9), .PLAY_SECONDS(10), .LIVES(3)
   ) dut (
      .Clk100M      (clk),
      .Rst_n        (rst_n),
      .Clk1Hz       (clk_1hz),
      .startBtn     (start_btn),
      .prelimDone   (prelim_done),
      .answerValid  (answer_valid),
      .answerCorrect(answer_correct),
      .prelimSig    (prelim_sig),
      .playEn       (play_en),
      .curLevel     (cur_level),
      .livesLeft    (lives_left),
      .secondsLeft  (seconds_left),
      .state        (state),
      .gameWon      (game_won),
      .gameOver     (game_over)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checker
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // drivers (all inputs change just after a falling edge)
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start_btn = 1'b1;
      cyc(1);
      start_btn = 1'b0;
   endtask

   task automatic answer(input logic correct);
      answer_valid   = 1'b1;
      answer_correct = correct;
      cyc(1);
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
   endtask

   // prelimDone pulse: edge-detect flop then state change => PLAY after 2 edges
   task automatic prelim_rise();
      prelim_done = 1'b1;
      cyc(2);
      prelim_done = 1'b0;
   endtask

   // rising 1 Hz transition: takes effect on the third clock edge
   task automatic hz_rise();
      clk_1hz = 1'b1;
      cyc(3);
   endtask

   task automatic hz_fall();
      clk_1hz = 1'b0;
      cyc(3);
   endtask

   initial begin
      n_vec          = 0;
      n_err          = 0;
      rst_n          = 1'b0;
      clk_1hz        = 1'b0;
      start_btn      = 1'b0;
      prelim_done    = 1'b0;
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      cyc(3);

      // reset state
      chk("rst_state",   state,        8'd0);
      chk("rst_prelim",  prelim_sig,   8'd0);
      chk("rst_play",    play_en,      8'd0);
      chk("rst_level",   cur_level,    8'd0);
      chk("rst_lives",   lives_left,   8'd3);
      chk("rst_secs",    seconds_left, 8'd0);
      chk("rst_won",     game_won,     8'd0);
      chk("rst_over",    game_over,    8'd0);
      rst_n = 1'b1;
      cyc(2);

      // start from IDLE
      pulse_start();
      chk("start_state",  state,      8'd1);
      chk("start_prelim", prelim_sig, 8'd1);
      chk("start_level",  cur_level,  8'd0);
      chk("start_lives",  lives_left, 8'd3);

      // answer ignored in PRELIM
      answer(1'b1);
      chk("ans_in_prelim_state", state,     8'd1);
      chk("ans_in_prelim_level", cur_level, 8'd0);

      prelim_rise();
      chk("play_state",  state,        8'd2);
      chk("play_en",     play_en,      8'd1);
      chk("play_prelim", prelim_sig,   8'd0);
      chk("play_secs",   seconds_left, 8'd10);

      // start ignored in PLAY
      pulse_start();
      chk("start_in_play", state, 8'd2);

      // correct answers through to win
      for (int lvl = 0; lvl < 9; lvl++) begin
         answer(1'b1);
         chk("win_lvl",    cur_level, 8'(lvl + 1));
         chk("win_prelim", state,     8'd1);
         prelim_rise();
         chk("win_play",   state,     8'd2);
      end
      answer(1'b1);
      chk("won_state", state,     8'd3);
      chk("won_flag",  game_won,  8'd1);
      chk("won_level", cur_level, 8'd9);
      chk("won_play",  play_en,   8'd0);
      cyc(3);
      chk("won_hold",  state,     8'd3);

      // restart from WIN
      pulse_start();
      chk("rewin_state", state,      8'd1);
      chk("rewin_level", cur_level,  8'd0);
      chk("rewin_lives", lives_left, 8'd3);
      chk("rewin_won",   game_won,   8'd0);
      prelim_rise();
      chk("rewin_secs",  seconds_left, 8'd10);

      // timeout: ten 1 Hz edges
      for (int i = 0; i < 10; i++) begin
         hz_rise();
         if (i < 9) begin
            chk("to_secs",  seconds_left, 8'(9 - i));
            chk("to_state", state,        8'd2);
         end else begin
            chk("to_secs0",  seconds_left, 8'd0);
            chk("to_lives",  lives_left,   8'd2);
            chk("to_state1", state,        8'd1);
            chk("to_level",  cur_level,    8'd0);
         end
         hz_fall();
      end

      // 1 Hz edge and start ignored in PRELIM
      hz_rise();
      hz_fall();
      chk("hz_in_prelim", seconds_left, 8'd0);
      pulse_start();
      chk("start_in_prelim", lives_left, 8'd2);

      // wrong answers down to LOSE
      prelim_rise();
      answer(1'b0);
      chk("wrong_lives1", lives_left, 8'd1);
      chk("wrong_state1", state,      8'd1);
      prelim_rise();
      answer(1'b0);
      chk("wrong_lives0", lives_left, 8'd0);
      chk("lose_state",   state,      8'd4);
      chk("lose_flag",    game_over,  8'd1);
      answer(1'b1);
      chk("ans_in_lose",  cur_level,  8'd0);

      pulse_start();
      chk("relose_state", state,      8'd1);
      chk("relose_lives", lives_left, 8'd3);
      chk("relose_level", cur_level,  8'd0);
      chk("relose_over",  game_over,  8'd0);

      // three wrong answers from full lives
      for (int k = 0; k < 3; k++) begin
         prelim_rise();
         answer(1'b0);
         chk("wrong3_lives", lives_left, 8'(2 - k));
         chk("wrong3_state", state,      (k == 2) ? 8'd4 : 8'd1);
      end
      pulse_start();
      chk("re3_lives", lives_left, 8'd3);

      // correct answer in the same cycle as the final 1 Hz edge
      prelim_rise();
      for (int i = 0; i < 9; i++) begin
         hz_rise();
         hz_fall();
      end
      chk("sim_secs1", seconds_left, 8'd1);
      clk_1hz = 1'b1;
      cyc(2);
      answer(1'b1);
      chk("sim_level", cur_level,    8'd1);
      chk("sim_lives", lives_left,   8'd3);
      chk("sim_state", state,        8'd1);
      chk("sim_secs",  seconds_left, 8'd1);
      hz_fall();

      // prelimDone held high across re-entry to PRELIM
      prelim_done = 1'b1;
      cyc(2);
      chk("hold_play", state, 8'd2);
      answer(1'b1);
      cyc(4);
      chk("hold_no_play",   state,     8'd1);
      chk("hold_level",     cur_level, 8'd2);
      prelim_done = 1'b0;
      cyc(2);
      chk("hold_low_prelim", state, 8'd1);
      prelim_done = 1'b1;
      cyc(2);
      chk("hold_fresh_play", state, 8'd2);
      prelim_done = 1'b0;

      // reach level 4 in PLAY, then reset asynchronously
      answer(1'b1);
      prelim_rise();
      answer(1'b1);
      prelim_rise();
      chk("pre_rst_level", cur_level, 8'd4);
      hz_rise();
      hz_fall();
      chk("pre_rst_secs", seconds_left, 8'd9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", state,        8'd0);
      chk("arst_level", cur_level,    8'd0);
      chk("arst_play",  play_en,      8'd0);
      chk("arst_secs",  seconds_left, 8'd0);
      chk("arst_lives", lives_left,   8'd3);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      chk("post_rst_state", state, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
